regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file with pending-write scoreboard and sequential initialisation for the RISC-V core. Sits between decode/issue and writeback. Serves NRD combinational operand reads per cycle, tracks registers awaiting writeback as busy, and clears its array by a one-entry-per-cycle sweep after reset so that large NREGS maps onto plain RAM.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: architectural register count; power of two, ≥ 4. AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.
- SP_IDX, 2: index loaded with SP_INIT during the init sweep.
- SP_INIT, 32'h0000_0000: stack-pointer reset value, zero-extended or truncated to XLEN.

- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-low reset.
- ready_o  out  1  high once the init sweep has finished.
- raddr_i  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata_o  out  NRD*XLEN  packed read data.
- rbusy_o  out  NRD  per-port busy flag of the addressed register.
- iss_valid_i  in  1  an instruction with destination iss_addr_i is issuing.
- iss_addr_i  in  AW  destination of the issuing instruction.
- we_i  in  1  writeback strobe.
- waddr_i  in  AW  writeback address.
- wdata_i  in  XLEN  writeback data.

## Operation
- States: INIT, READY.
- Reset (rst_i low at an edge): state←INIT, sweep index←1, all busy bits←0. Array contents are left alone.
- INIT: at each edge, entry[idx]←0, or SP_INIT if idx==SP_IDX. Then idx←idx+1. The edge that writes NREGS−1 moves the state to READY.
- INIT: we_i and iss_valid_i are ignored. rdata_o=0, rbusy_o=0.
- READY: if we_i and waddr_i≠0, then entry[waddr_i]←wdata_i and busy[waddr_i]←0.
- READY: if iss_valid_i and iss_addr_i≠0, then busy[iss_addr_i]←1.
- Issue and writeback to the same address in one cycle: issue wins, so busy stays 1 (a newer producer exists). The data is still written.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- Register 0: reads return 0, rbusy=0. Writes and issues to it are discarded.
- Read port k: rdata = entry[raddr_k] and rbusy = busy[raddr_k], subject to the x0 and bypass rules.
- Several ports may address the same register; each returns identical data.
- Reset mid-sweep or mid-operation restarts INIT from idx 1 and clears all busy bits.

## Timing
- Reset values: ready_o=0, rdata_o=0, rbusy_o=0.
- ready_o is registered. It rises on the (NREGS−1)th rising edge with rst_i high, which is edge 31 for the default.
- Reads are combinational from raddr_i: zero latency.
- Writes and busy updates become visible in the cycle after the edge, or in the same cycle when bypassed (see Configuration).
- The scoreboard is not bypassed: an issue in cycle N shows rbusy=1 from cycle N+1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In READY, a read port with raddr==waddr_i≠0 and we_i=1 returns wdata_i combinationally.
  - Its rbusy is 0, unless iss_valid_i is also targeting that address in the same cycle, in which case it is still 0 this cycle and 1 from the next.
- REGFILE_BYPASS_EN undefined: reads return the pre-edge array content and busy state, and a written value appears in cycle N+1.

## Test plan
- Reset and sweep: hold rst_i low 3 cycles then release → ready_o=0 for 30 edges and 1 at edge 31. Then x2 reads SP_INIT, x5 reads 0, every rbusy=0.
- Write/read on all ports: write x7=32'hDEAD_BEEF, then read x7 on ports 0 and 1 → both 32'hDEAD_BEEF. Write x0=32'h1234 → x0 reads 0.
- Scoreboard: issue x9, then hold 3 idle cycles → rbusy for x9 = 1. Write back x9=32'h55 → next cycle rbusy=0 and data=32'h55.
- Simultaneous issue and writeback to x9 → data updated, busy remains 1.
- Bypass: in one cycle write x3=32'hA5A5_A5A5 while port 0 reads x3 → with REGFILE_BYPASS_EN, 32'hA5A5_A5A5 in the same cycle; without it, the old value, then the new one next cycle.
- Mid-operation reset: set busy x4, write x4=32'h77, pulse rst_i low 1 cycle → ready_o drops and returns 31 edges later, x4 reads 0, rbusy=0. Writes during the sweep have no effect.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read-port register file with busy scoreboard and post-reset init sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int          XLEN    = 32,
    parameter int          NREGS   = 32,
    parameter int          NRD     = 2,
    parameter int          SP_IDX  = 2,
    parameter logic [31:0] SP_INIT = 32'h0000_0000,
    localparam int         AW      = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                ready_o,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    idx, idx_nxt;
    logic [NREGS-1:0] busy, busy_nxt;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [XLEN-1:0]  mem_wd;
    logic [XLEN-1:0]  mem [NREGS];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= INIT;
            idx   <= AW'(1);
            busy  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= busy_nxt;
        end
    end

    // Single write port shared by the sweep and writeback keeps the array RAM-mappable.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = busy;
        mem_we    = 1'b0;
        mem_wa    = waddr_i;
        mem_wd    = wdata_i;
        unique case (state)
            INIT: begin
                mem_we  = 1'b1;
                mem_wa  = idx;
                mem_wd  = (idx == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
                idx_nxt = idx + AW'(1);
                if (idx == AW'(NREGS - 1)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (we_i && (waddr_i != '0)) begin
                    mem_we            = 1'b1;
                    busy_nxt[waddr_i] = 1'b0;
                end
                // Issue applied last: a newer producer keeps the register busy.
                if (iss_valid_i && (iss_addr_i != '0)) begin
                    busy_nxt[iss_addr_i] = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign ready_o = (state == READY);

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = raddr_i[k*AW +: AW];
        assign hit = (state == READY) && (a != '0);
`ifdef REGFILE_BYPASS_EN
        logic byp;
        assign byp = hit && we_i && (waddr_i == a);
        assign rdata_o[k*XLEN +: XLEN] = !hit ? '0 : (byp ? wdata_i : mem[a]);
        assign rbusy_o[k] = hit && !byp && busy[a];
`else
        assign rdata_o[k*XLEN +: XLEN] = hit ? mem[a] : '0;
        assign rbusy_o[k] = hit && busy[a];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp against an array model.
module tb_regfile_mp;

    localparam int          XLEN  = 32;
    localparam int          NREGS = 32;
    localparam int          NRD   = 2;
    localparam int          AW    = 5;
    localparam logic [31:0] SP    = 32'h8000_1000;

    logic                clk = 1'b0;
    logic                rst;
    logic                ready;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                iss_valid;
    logic [AW-1:0]       iss_addr;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_IDX(2), .SP_INIT(SP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ready_o(ready),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata)
    );

    int vecs = 0;
    int errs = 0;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];
    bit              m_ready;
    int              m_swept;

    function automatic logic [XLEN-1:0] exp_rd(int a);
        if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && int'(waddr) == a) return wdata;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && int'(waddr) == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            m_ready = 1'b0;
            m_swept = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (!m_ready) begin
            m_swept++;
            m_mem[m_swept] = (m_swept == 2) ? SP : '0;
            if (m_swept == NREGS - 1) m_ready = 1'b1;
        end else begin
            if (we && waddr != 0) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic check(string tag);
        #1;
        vecs++;
        assert (ready === m_ready) else begin
            errs++;
            $error("FAIL %s ready got %b exp %b", tag, ready, m_ready);
        end
        for (int k = 0; k < NRD; k++) begin
            int a = int'(raddr[k*AW +: AW]);
            vecs++;
            assert (rdata[k*XLEN +: XLEN] === exp_rd(a)) else begin
                errs++;
                $error("FAIL %s rdata%0d x%0d got %h exp %h",
                       tag, k, a, rdata[k*XLEN +: XLEN], exp_rd(a));
            end
            vecs++;
            assert (rbusy[k] === exp_busy(a)) else begin
                errs++;
                $error("FAIL %s rbusy%0d x%0d got %b exp %b",
                       tag, k, a, rbusy[k], exp_busy(a));
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we        = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic set_rd(int k, int a);
        raddr[k*AW +: AW] = AW'(a);
    endtask

    task automatic cyc(string tag);
        check(tag);
        step();
    endtask

    task automatic rand_wr();
        we        = 1'($urandom);
        waddr     = AW'($urandom);
        wdata     = $urandom;
        iss_valid = 1'($urandom);
        iss_addr  = AW'($urandom);
    endtask

    initial begin
        int n;
        foreach (m_mem[i]) m_mem[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ready = 1'b0;
        m_swept = 0;
        rst = 1'b0;
        idle();
        raddr = '0;
        waddr = '0;
        wdata = '0;
        iss_addr = '0;

        step();
        cyc("reset");
        cyc("reset");
        rst = 1'b1;
        set_rd(0, 2);
        set_rd(1, 5);
        n = 0;
        while (!ready && n < 100) begin
            cyc("sweep");
            n++;
        end
        chk("sweep_len", 32'(n), 32'd31);
        check("sp");
        chk("sp_x2", rdata[31:0], SP);
        chk("sp_x5", rdata[63:32], 32'h0);
        step();

        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        set_rd(0, 7);
        set_rd(1, 7);
        cyc("wr7");
        idle();
        check("rd7");
        chk("rd7_p0", rdata[31:0], 32'hDEAD_BEEF);
        chk("rd7_p1", rdata[63:32], 32'hDEAD_BEEF);
        step();

        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        set_rd(0, 0);
        cyc("wr0");
        idle();
        check("rd0");
        chk("rd0_p0", rdata[31:0], 32'h0);
        step();

        iss_valid = 1'b1; iss_addr = 5'd9;
        set_rd(0, 9);
        set_rd(1, 9);
        cyc("iss9");
        idle();
        cyc("idle9");
        cyc("idle9");
        check("idle9");
        chk("busy9", 32'(rbusy[0]), 32'd1);
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        cyc("wb9");
        idle();
        check("after_wb9");
        chk("wb9_busy", 32'(rbusy[0]), 32'd0);
        chk("wb9_data", rdata[31:0], 32'h55);
        step();

        we = 1'b1; waddr = 5'd9; wdata = 32'h66;
        iss_valid = 1'b1; iss_addr = 5'd9;
        cyc("iss_wb9");
        idle();
        check("after_iss_wb9");
        chk("iss_wb9_busy", 32'(rbusy[1]), 32'd1);
        chk("iss_wb9_data", rdata[63:32], 32'h66);
        step();

        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        set_rd(0, 3);
        check("byp");
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rdata[31:0], 32'hA5A5_A5A5);
`else
        chk("byp_old", rdata[31:0], 32'h0);
`endif
        step();
        idle();
        check("byp_next");
        chk("byp_next", rdata[31:0], 32'hA5A5_A5A5);
        step();

        iss_valid = 1'b1; iss_addr = 5'd4;
        set_rd(0, 4);
        cyc("iss4");
        idle();
        we = 1'b1; waddr = 5'd4; wdata = 32'h77;
        cyc("wr4");
        idle();
        check("rd4");
        chk("rd4", rdata[31:0], 32'h77);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            rand_wr();
            cyc("resweep");
            n++;
        end
        idle();
        chk("resweep_len", 32'(n), 32'd31);
        set_rd(0, 4);
        check("x4_cleared");
        chk("x4_data", rdata[31:0], 32'h0);
        chk("x4_busy", 32'(rbusy[0]), 32'd0);
        step();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            rand_wr();
            for (int k = 0; k < NRD; k++) set_rd(k, $urandom_range(0, NREGS - 1));
            cyc("rand");
        end
        rst = 1'b1;
        idle();
        cyc("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
